// File: rtl/neander_pkg.sv
// Shared constants for the Neander sequencer: opcodes, ALU selects and FSM states.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    S_F0,
    S_F1,
    S_O0,
    S_O1,
    S_ST,
    S_D0,
    S_D1,
    S_HLT
  } state_t;

endpackage

// File: rtl/neander_decode.sv
// Combinational opcode classifier; jump "taken" folds in the current N/Z flags.
module neander_decode
  import neander_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       flag_n,
  input  logic       flag_z,
  output logic       needs_operand,
  output logic       is_store,
  output logic       is_load,
  output logic       is_alu,
  output logic       is_jump,
  output logic       is_jump_taken,
  output logic       is_halt,
  output logic [1:0] alu_sel
);

  always_comb begin
    needs_operand = 1'b0;
    is_store      = 1'b0;
    is_load       = 1'b0;
    is_alu        = 1'b0;
    is_jump       = 1'b0;
    is_jump_taken = 1'b0;
    is_halt       = 1'b0;
    alu_sel       = ALU_ADD;
    case (opcode)
      OP_STA: begin
        is_store      = 1'b1;
        needs_operand = 1'b1;
      end
      OP_LDA: begin
        is_load       = 1'b1;
        needs_operand = 1'b1;
      end
      OP_ADD: begin
        is_alu        = 1'b1;
        needs_operand = 1'b1;
        alu_sel       = ALU_ADD;
      end
      OP_OR: begin
        is_alu        = 1'b1;
        needs_operand = 1'b1;
        alu_sel       = ALU_OR;
      end
      OP_AND: begin
        is_alu        = 1'b1;
        needs_operand = 1'b1;
        alu_sel       = ALU_AND;
      end
      OP_NOT: begin
        // Single-operand op: executes straight out of the fetch cycle.
        is_alu        = 1'b1;
        alu_sel       = ALU_NOT;
      end
      OP_JMP: begin
        is_jump       = 1'b1;
        is_jump_taken = 1'b1;
        needs_operand = 1'b1;
      end
      OP_JN: begin
        is_jump       = 1'b1;
        is_jump_taken = flag_n;
        needs_operand = flag_n;
      end
      OP_JZ: begin
        is_jump       = 1'b1;
        is_jump_taken = flag_z;
        needs_operand = flag_z;
      end
      OP_HLT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/neander_ctrl.sv
// Neander sequencer: fetch/operand/data FSM owning PC, AC, RI, REM and N/Z.
module neander_ctrl
  import neander_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [1:0]        alu_sel,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  output logic [7:0]        ac,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_n,
  output logic              flag_z,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [7:0]        ac_q, ac_d;
  // Only the opcode nibble of RI is ever consumed after the fetch cycle.
  logic [3:0]        ri_q, ri_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              we_q, we_d;
  logic              halt_q, halt_d;

  logic [3:0] opcode;
  logic       dec_needs, dec_store, dec_load, dec_alu;
  logic       dec_jump, dec_taken, dec_halt;
  logic [1:0] dec_alu_sel;
  logic       ac_write;
  logic [7:0] ac_new;

  // During S_F1 the instruction is still on the read bus, not yet in RI.
  assign opcode = (state_q == S_F1) ? mem_rdata[7:4] : ri_q;

  neander_decode u_decode (
    .opcode        (opcode),
    .flag_n        (n_q),
    .flag_z        (z_q),
    .needs_operand (dec_needs),
    .is_store      (dec_store),
    .is_load       (dec_load),
    .is_alu        (dec_alu),
    .is_jump       (dec_jump),
    .is_jump_taken (dec_taken),
    .is_halt       (dec_halt),
    .alu_sel       (dec_alu_sel)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rem_d    = rem_q;
    ac_d     = ac_q;
    ri_d     = ri_q;
    n_d      = n_q;
    z_d      = z_q;
    alu_sel  = ALU_ADD;
    ac_write = 1'b0;
    ac_new   = ac_q;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: begin
        ri_d = mem_rdata[7:4];
        pc_d = pc_q + ADDR_W'(1);
        if (dec_halt) begin
          state_d = S_HLT;
        end else if (dec_alu && !dec_needs) begin
          alu_sel  = dec_alu_sel;
          ac_write = 1'b1;
          ac_new   = alu_result;
          state_d  = S_F0;
        end else if (dec_needs) begin
          state_d = S_O0;
        end else if (dec_jump) begin
          // Untaken conditional jump: step over its operand byte.
          pc_d    = pc_q + ADDR_W'(2);
          state_d = S_F0;
        end else begin
          state_d = S_F0;
        end
      end
      S_O0: state_d = S_O1;
      S_O1: begin
        rem_d = mem_rdata;
        if (dec_taken) begin
          pc_d    = mem_rdata;
          state_d = S_F0;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = dec_store ? S_ST : S_D0;
        end
      end
      S_ST: state_d = S_F0;
      S_D0: state_d = S_D1;
      S_D1: begin
        ac_write = 1'b1;
        if (dec_load) begin
          ac_new = mem_rdata;
        end else begin
          alu_sel = dec_alu_sel;
          ac_new  = alu_result;
        end
        state_d = S_F0;
      end
      S_HLT: state_d = S_HLT;
      default: state_d = S_F0;
    endcase
    if (ac_write) begin
      ac_d = ac_new;
      n_d  = ac_new[7];
      z_d  = (ac_new == 8'h00);
    end
    we_d   = (state_d == S_ST);
    halt_d = (state_d == S_HLT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_F0;
      pc_q    <= PC_RESET;
      rem_q   <= '0;
      ac_q    <= 8'h00;
      ri_q    <= 4'h0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
      ac_q    <= ac_d;
      ri_q    <= ri_d;
      n_q     <= n_d;
      z_q     <= z_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
    end
  end

  assign mem_addr  = (state_q == S_ST || state_q == S_D0 || state_q == S_D1) ? rem_q : pc_q;
  assign mem_wdata = ac_q;
  assign mem_we    = we_q;
  assign alu_a     = ac_q;
  assign alu_b     = mem_rdata;
  assign ac        = ac_q;
  assign pc        = pc_q;
  assign flag_n    = n_q;
  assign flag_z    = z_q;
  assign halted    = halt_q;

endmodule

// File: tb/tb_neander_ctrl.sv
// Scoreboard bench for neander_ctrl: directed programs, expected writes/halts queued and checked by a monitor.
module tb_neander_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, alu_a, alu_b, alu_result, ac, pc;
  logic       mem_we, flag_n, flag_z, halted;
  logic [1:0] alu_sel;

  always #5 clk = ~clk;

  neander_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .ac         (ac),
    .pc         (pc),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .halted     (halted)
  );

  always_comb begin
    alu_result = ~alu_a;
    case (alu_sel)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a & alu_b;
      2'b10: alu_result = alu_a | alu_b;
      default: alu_result = ~alu_a;
    endcase
  end

  // Synchronous RAM with 1-cycle read latency and a bench-side load port.
  logic [7:0] ram [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; logic n; logic z; } wr_t;
  typedef struct { logic [7:0] ac; logic [7:0] pc; logic n; logic z; int cyc; } halt_t;
  wr_t   exp_wr[$];
  halt_t exp_halt[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT writes or enters halt.
  initial begin
    logic  hp;
    wr_t   w;
    halt_t h;
    hp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hp = 1'b0;
      end else begin
        if (mem_we) begin
          chk("wr_pending", int'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w.addr);
            chk("wr_data", mem_wdata, w.data);
            chk("wr_cycle", cyc + 1, w.cyc);
            chk("wr_flag_n", flag_n, w.n);
            chk("wr_flag_z", flag_z, w.z);
          end
          $display("write addr=%02h data=%02h cycle=%0d", mem_addr, mem_wdata, cyc + 1);
        end
        if (halted && !hp) begin
          chk("halt_pending", int'(exp_halt.size() > 0), 1);
          if (exp_halt.size() > 0) begin
            h = exp_halt.pop_front();
            chk("halt_ac", ac, h.ac);
            chk("halt_pc", pc, h.pc);
            chk("halt_flag_n", flag_n, h.n);
            chk("halt_flag_z", flag_z, h.z);
            chk("halt_cycle", cyc, h.cyc);
          end
          $display("halt ac=%02h pc=%02h n=%0b z=%0b cycle=%0d", ac, pc, flag_n, flag_z, cyc);
        end
        hp = halted;
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic start_test();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string nm, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_drained"}, exp_wr.size() + exp_halt.size(), 0);
    exp_wr.delete();
    exp_halt.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ff_seen;

    // Test 1: LDA/ADD/STA/HLT, plus reset-state checks.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h30); poke(8'h03, 8'h81);
    poke(8'h04, 8'h10); poke(8'h05, 8'h82);
    poke(8'h06, 8'hF0);
    poke(8'h80, 8'h05); poke(8'h81, 8'h03);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ac", ac, 8'h00);
    chk("rst_n", flag_n, 0);
    chk("rst_z", flag_z, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_alu_sel", alu_sel, 0);
    exp_wr.push_back('{8'h82, 8'h08, 17, 1'b0, 1'b0});
    exp_halt.push_back('{8'h08, 8'h07, 1'b0, 1'b0, 19});
    release_rst();
    run_to_halt("t1", 100);
    chk("t1_ram82", ram[8'h82], 8'h08);

    // Test 2: LDA 80h, NOT, STA, AND 00h, STA.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h60);
    poke(8'h03, 8'h10); poke(8'h04, 8'h90);
    poke(8'h05, 8'h50); poke(8'h06, 8'h81);
    poke(8'h07, 8'h10); poke(8'h08, 8'h91);
    poke(8'h09, 8'hF0);
    poke(8'h80, 8'h80); poke(8'h81, 8'h00);
    exp_wr.push_back('{8'h90, 8'h7F, 13, 1'b0, 1'b0});
    exp_wr.push_back('{8'h91, 8'h00, 24, 1'b0, 1'b1});
    exp_halt.push_back('{8'h00, 8'h0A, 1'b0, 1'b1, 26});
    release_rst();
    run_to_halt("t2", 100);

    // Test 3a: LDA FFh then JN 20 taken.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h90); poke(8'h03, 8'h20);
    poke(8'h20, 8'hF0);
    poke(8'h80, 8'hFF);
    exp_halt.push_back('{8'hFF, 8'h21, 1'b1, 1'b0, 12});
    release_rst();
    run_to_halt("t3a", 100);

    // Test 3b: JMP 10, JN at 10 with N=0 falls through to 12.
    start_test();
    poke(8'h00, 8'h80); poke(8'h01, 8'h10);
    poke(8'h10, 8'h90); poke(8'h11, 8'h40);
    poke(8'h12, 8'hF0);
    poke(8'h40, 8'hF0);
    exp_halt.push_back('{8'h00, 8'h13, 1'b0, 1'b1, 8});
    release_rst();
    run_to_halt("t3b", 100);

    // Test 4: JZ at FE with Z=0 wraps PC to 00 without an operand read.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h80); poke(8'h03, 8'hFE);
    poke(8'hFE, 8'hA0); poke(8'hFF, 8'h55);
    poke(8'h80, 8'h01);
    release_rst();
    ff_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_addr == 8'hFF) ff_seen = 1'b1;
    end
    chk("t4_pc_wrap", pc, 8'h00);
    chk("t4_no_operand_read", ff_seen, 0);
    chk("t4_ac", ac, 8'h01);
    chk("t4_z", flag_z, 0);
    $display("t4 jz-wrap pc=%02h ff_read=%0b", pc, ff_seen);

    // Test 5: reset asserted during the STA store cycle.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h10); poke(8'h03, 8'h90);
    poke(8'h04, 8'hF0);
    poke(8'h80, 8'hAA); poke(8'h90, 8'h5A);
    release_rst();
    repeat (10) @(posedge clk);
    #1;
    chk("t5_in_store", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("t5_we_drop", mem_we, 0);
    chk("t5_pc", pc, 8'h00);
    chk("t5_ac", ac, 8'h00);
    chk("t5_z", flag_z, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_ram90", ram[8'h90], 8'h5A);
    $display("t5 reset-in-store we=%0b ram90=%02h", mem_we, ram[8'h90]);

    // Test 6: opcodes 7x and Cx act as NOPs.
    start_test();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h73);
    poke(8'h03, 8'hC5);
    poke(8'h04, 8'h10); poke(8'h05, 8'h90);
    poke(8'h06, 8'hF0);
    poke(8'h80, 8'h85);
    exp_wr.push_back('{8'h90, 8'h85, 15, 1'b1, 1'b0});
    exp_halt.push_back('{8'h85, 8'h07, 1'b1, 1'b0, 17});
    release_rst();
    run_to_halt("t6", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neander_ctrl.md
Name: neander_ctrl

Overview:
- Sequencer and register file for the Neander CPU.
- Fetches, decodes and executes 8-bit Neander instructions from a synchronous RAM.
- Owns PC, AC, RI, REM and the N/Z flags.
- Drives the ALU operation select (00 ADD, 01 AND, 10 OR, 11 NOT) and operands into the existing ALU output mux, and latches the ALU result back into AC.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- ADDR_W, 8, address width; PC/REM width. Only 8 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  8  RAM address; combinational from state: PC in fetch/operand states, REM in data/store states.
- mem_rdata  in  8  RAM read data; valid the cycle after mem_addr is presented (1-cycle read latency).
- mem_wdata  out  8  RAM write data; always equals AC.
- mem_we  out  1  RAM write strobe; high only in S_ST.
- alu_sel  out  2  ALU op: 00 ADD, 01 AND, 10 OR, 11 NOT. Held at 00 outside execute cycles.
- alu_a  out  8  ALU operand A, equals AC.
- alu_b  out  8  ALU operand B, equals mem_rdata.
- alu_result  in  8  ALU output; combinational from alu_sel/alu_a/alu_b.
- ac  out  8  accumulator.
- pc  out  8  program counter.
- flag_n  out  1  negative flag (AC[7]).
- flag_z  out  1  zero flag (AC==0).
- halted  out  1  high while in S_HLT.

Behaviour:
- Reset (async, immediate): state=S_F0, PC=PC_RESET, AC=0, RI=0, REM=0, N=0, Z=1, mem_we=0, alu_sel=00, halted=0.
- Reset mid-instruction aborts it; no write is issued after rst rises.
- Opcode = RI[7:4]:
  - 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT.
  - 7 and B-E execute as NOP.
- S_F0: mem_addr=PC -> S_F1.
- S_F1: RI<=rdata; PC<=PC+1. Decode rdata[7:4]:
  - NOP/undefined -> S_F0.
  - HLT -> S_HLT.
  - NOT: alu_sel=11, AC<=alu_result, update N/Z -> S_F0.
  - JN with N=0, or JZ with Z=0: PC<=PC+2 (skip operand) -> S_F0.
  - All others -> S_O0.
- S_O0: mem_addr=PC -> S_O1.
- S_O1: REM<=rdata.
  - JMP, JN taken, JZ taken: PC<=rdata -> S_F0.
  - Otherwise PC<=PC+1.
  - STA -> S_ST; LDA/ADD/OR/AND -> S_D0.
- S_ST: mem_addr=REM, mem_we=1, mem_wdata=AC -> S_F0.
- S_D0: mem_addr=REM -> S_D1.
- S_D1 (all update N/Z, then -> S_F0):
  - LDA: AC<=rdata.
  - ADD: alu_sel=00, AC<=alu_result.
  - AND: alu_sel=01, AC<=alu_result.
  - OR: alu_sel=10, AC<=alu_result.
- N/Z update: N<=new AC[7]; Z<=(new AC==0). Flags change only on AC writes. STA and jumps leave flags unchanged.
- Arithmetic: PC increments wrap modulo 256 (FF+1=00, FE+2=00). ADD carry is discarded.
- S_HLT: all registers hold, mem_we=0, halted=1. Exit only via rst.
- Cycle counts: NOP/NOT/not-taken jump 2; JMP/taken jump 4; STA 5; LDA/ADD/OR/AND 6; HLT 2 to enter S_HLT.

Decomposition:
- Package neander_pkg holds:
  - opcode constants (OP_NOP..OP_HLT);
  - ALU select constants (ALU_ADD=2'b00, ALU_AND=2'b01, ALU_OR=2'b10, ALU_NOT=2'b11);
  - state enum (S_F0, S_F1, S_O0, S_O1, S_ST, S_D0, S_D1, S_HLT).
- One sub-module: neander_decode, combinational. Maps opcode plus N/Z to:
  - class flags: needs_operand, is_store, is_load, is_alu, is_jump_taken, is_halt;
  - alu_sel.

Test Plan:
1. RAM: 00:LDA 80, 02:ADD 81, 04:STA 82, 06:HLT; [80]=05, [81]=03. Required response:
   - write of 08 at addr 82, 17 cycles after reset release;
   - AC=08, N=0, Z=0, halted=1, PC=07.
2. LDA of 80h, then NOT. Required: AC=7F, N=0, Z=0. Then AND with 00h: AC=00, Z=1.
3. LDA of FFh then JN 20. Required: PC=20 four cycles after JN fetch. With N=0, JN at 10 gives PC=12 after 2 cycles.
4. JZ at FE with Z=0. Required: PC wraps to 00, no operand read issued.
5. Assert rst during S_ST cycle of STA. Required: mem_we drops in the same cycle, RAM unchanged, PC=00, AC=00, Z=1.
6. Opcode 7xh and Cxh. Required: behave as 2-cycle NOP, PC+1, AC/flags unchanged, no write.
